// File: rtl/mmio_bus_arbiter.sv
// Two-master round-robin arbiter driving a single APB-style MMIO bus.
// One transfer at a time: SETUP, ACCESS (waits on pready or times out), then RESP.
module mmio_bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_done,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        pwrite,
  output logic [3:0]  psel,
  output logic        penable,
  input  logic        pready,
  input  logic [31:0] prdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last;
  logic             r_gnt_id;
  logic [CNT_W-1:0] r_cnt;

  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic        r_pwrite;
  logic [3:0]  r_psel;
  logic        r_penable;
  logic        r_m0_done;
  logic        r_m0_err;
  logic [31:0] r_m0_rdata;
  logic        r_m1_done;
  logic        r_m1_err;
  logic [31:0] r_m1_rdata;

  logic        w_any_req;
  logic        w_winner;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_write;
  logic        w_timeout;
  logic        w_acc_end;
  logic [31:0] w_rdata_cap;

  always_comb begin
    w_any_req = m0_req | m1_req;
    // On a tie the master that was not served last wins.
    w_winner  = m1_req;
    if (m0_req && m1_req) begin
      w_winner = ~r_last;
    end
    w_addr      = w_winner ? m1_addr  : m0_addr;
    w_wdata     = w_winner ? m1_wdata : m0_wdata;
    w_write     = w_winner ? m1_write : m0_write;
    w_timeout   = !pready && (r_cnt == CNT_W'(TIMEOUT - 1));
    w_acc_end   = pready || w_timeout;
    w_rdata_cap = (pready && !r_pwrite) ? prdata : 32'd0;

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_acc_end) w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last     <= 1'b1;
      r_gnt_id   <= 1'b0;
      r_cnt      <= '0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_pwrite   <= 1'b0;
      r_psel     <= '0;
      r_penable  <= 1'b0;
      r_m0_done  <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_done  <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m1_rdata <= '0;
    end else begin
      r_m0_done <= 1'b0;
      r_m1_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt_id <= w_winner;
            r_paddr  <= w_addr;
            r_pwdata <= w_wdata;
            r_pwrite <= w_write;
            r_psel   <= 4'b0001 << w_addr[9:8];
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Only the granted master's response registers are touched.
          if (w_acc_end) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            if (r_gnt_id) begin
              r_m1_done  <= 1'b1;
              r_m1_err   <= w_timeout;
              r_m1_rdata <= w_rdata_cap;
            end else begin
              r_m0_done  <= 1'b1;
              r_m0_err   <= w_timeout;
              r_m0_rdata <= w_rdata_cap;
            end
          end
        end
        S_RESP: begin
          r_last <= r_gnt_id;
          r_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign paddr    = r_paddr;
  assign pwdata   = r_pwdata;
  assign pwrite   = r_pwrite;
  assign psel     = r_psel;
  assign penable  = r_penable;
  assign m0_done  = r_m0_done;
  assign m0_err   = r_m0_err;
  assign m0_rdata = r_m0_rdata;
  assign m1_done  = r_m1_done;
  assign m1_err   = r_m1_err;
  assign m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Bench for mmio_bus_arbiter: directed scenarios plus randomized transfers
// against a transaction-level model (arbitration by last-served, latency by wait count).
module tb_mmio_bus_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_done, m0_err, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        pwrite, penable, pready;
  logic [3:0]  psel;

  mmio_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pready(pready), .prdata(prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          pend[2];
  bit          m_write[2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wdata[2];
  logic [31:0] ref_mem[256];
  logic [31:0] exp_rd[2];
  bit          exp_er[2];
  int          ref_last;
  int          exp_n[2];

  // Peripheral environment
  logic [31:0] mem[256];
  int          cur_waits;
  bit          stray;
  int          n_done[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    m0_req = pend[0]; m0_write = m_write[0]; m0_addr = m_addr[0]; m0_wdata = m_wdata[0];
    m1_req = pend[1]; m1_write = m_write[1]; m1_addr = m_addr[1]; m1_wdata = m_wdata[1];
  endtask

  task automatic post(input int m, input bit wr, input logic [31:0] a, input logic [31:0] d);
    pend[m] = 1'b1; m_write[m] = wr; m_addr[m] = a; m_wdata[m] = d;
    apply();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Serve one transfer starting in an IDLE cycle; check bus fields, latency and responses.
  task automatic serve(input int waits, input string tag);
    int win, oth, cyc, pen, exp_lat, exp_pen;
    bit got, tmo;
    logic [31:0] exp_r, exp_psel;
    cur_waits = waits;
    if (pend[0] && pend[1]) win = (ref_last == 1) ? 0 : 1;
    else win = pend[1] ? 1 : 0;
    oth = 1 - win;
    tmo = (waits > TIMEOUT - 1);
    exp_lat = tmo ? TIMEOUT + 2 : waits + 3;
    exp_pen = tmo ? TIMEOUT : waits + 1;
    exp_r = (tmo || m_write[win]) ? 32'd0 : ref_mem[m_addr[win][9:2]];
    exp_psel = 32'd1 << m_addr[win][9:8];
    cyc = 0; got = 0; pen = 0;
    while (!got && cyc <= 40) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk({tag, "_psel"}, {28'd0, psel}, exp_psel);
        chk({tag, "_penable_setup"}, 32'(penable), 32'd0);
        chk({tag, "_paddr"}, paddr, m_addr[win]);
        chk({tag, "_pwrite"}, 32'(pwrite), 32'(m_write[win]));
        chk({tag, "_pwdata"}, pwdata, m_wdata[win]);
      end
      if (penable) pen++;
      if (m0_done || m1_done) got = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_penable_cycles"}, 32'(pen), 32'(exp_pen));
    chk({tag, "_done_win"}, 32'(win ? m1_done : m0_done), 32'd1);
    chk({tag, "_done_oth"}, 32'(oth ? m1_done : m0_done), 32'd0);
    chk({tag, "_rdata_win"}, win ? m1_rdata : m0_rdata, exp_r);
    chk({tag, "_err_win"}, 32'(win ? m1_err : m0_err), 32'(tmo));
    chk({tag, "_rdata_oth"}, oth ? m1_rdata : m0_rdata, exp_rd[oth]);
    chk({tag, "_err_oth"}, 32'(oth ? m1_err : m0_err), 32'(exp_er[oth]));
    exp_rd[win] = exp_r;
    exp_er[win] = tmo;
    ref_last = win;
    exp_n[win]++;
    if (!tmo && m_write[win]) ref_mem[m_addr[win][9:2]] = m_wdata[win];
    @(posedge clk); #1;
    pend[win] = 1'b0;
    apply();
  endtask

  initial begin
    n_done[0] = 0; n_done[1] = 0;
    forever begin
      @(negedge clk);
      if (m0_done === 1'b1) n_done[0]++;
      if (m1_done === 1'b1) n_done[1]++;
    end
  end

  initial begin
    int acc;
    acc = 0; pready = 1'b0; prdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (penable === 1'b1) begin
        pready = (acc == cur_waits);
        acc++;
        prdata = mem[paddr[9:2]];
      end else begin
        acc = 0;
        pready = stray;
        prdata = $urandom;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (penable === 1'b1 && pready && pwrite === 1'b1 && !reset) mem[paddr[9:2]] = pwdata;
    end
  end

  initial begin
    logic [31:0] a, d;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      mem[i] = ref_mem[i];
    end
    ref_mem[64] = 32'hDEADBEEF; mem[64] = 32'hDEADBEEF;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 0; m_write[m] = 0; m_addr[m] = 0; m_wdata[m] = 0;
      exp_rd[m] = 0; exp_er[m] = 0; exp_n[m] = 0;
    end
    ref_last = 1; cur_waits = 0; stray = 1'b0;
    reset = 1'b1;
    apply();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_psel", {28'd0, psel}, 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_done", {30'd0, m1_done, m0_done}, 32'd0);
    chk("rst_err", {30'd0, m1_err, m0_err}, 32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    tick();
    reset = 1'b0;

    // Simultaneous requests out of reset, then alternating grants
    post(0, 1'b0, 32'h0000_0010, 32'h0);
    post(1, 1'b1, 32'h0000_0204, 32'hA5A5_0001);
    serve(0, "tie_first");
    serve(0, "tie_second");
    post(0, 1'b0, 32'h0000_0204, 32'h0);
    post(1, 1'b0, 32'h0000_0100, 32'h0);
    serve(0, "alt_a");
    post(0, 1'b1, 32'h0000_0108, 32'h1111_2222);
    serve(1, "alt_b");
    post(1, 1'b0, 32'h0000_0108, 32'h0);
    serve(0, "alt_c");
    serve(2, "alt_d");

    // Single read, write with wait states, timeout then normal transfer
    post(0, 1'b0, 32'h0000_0100, 32'h0);
    serve(0, "single_read");
    post(1, 1'b1, 32'h0000_0300, 32'h1234_5678);
    serve(3, "write_wait");
    post(0, 1'b0, 32'h0000_0300, 32'h0);
    serve(100, "timeout");
    post(0, 1'b0, 32'h0000_0300, 32'h0);
    serve(0, "after_timeout");

    // Stray pready while idle and through setup
    stray = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("stray_idle_psel", {28'd0, psel}, 32'd0);
    chk("stray_idle_done0", 32'(n_done[0]), 32'(exp_n[0]));
    chk("stray_idle_done1", 32'(n_done[1]), 32'(exp_n[1]));
    tick();
    post(1, 1'b0, 32'h0000_0044, 32'h0);
    serve(2, "stray_setup");
    stray = 1'b0;

    // Randomized transfers
    for (int it = 0; it < 40; it++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 1) == 1) begin
          a = $urandom; a[1:0] = 2'b00; d = $urandom;
          post(m, 1'($urandom_range(0, 1)), a, d);
        end
      end
      if (!pend[0] && !pend[1]) begin
        a = $urandom; a[1:0] = 2'b00; d = $urandom;
        post(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
      end
      serve(($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3)), "rnd");
    end
    while (pend[0] || pend[1]) serve(0, "drain");

    // Reset in the middle of an m1 access
    post(1, 1'b0, 32'h0000_0204, 32'h0);
    cur_waits = 100;
    repeat (4) tick();
    reset = 1'b1;
    pend[1] = 1'b0;
    apply();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_psel", {28'd0, psel}, 32'd0);
    chk("midrst_penable", 32'(penable), 32'd0);
    chk("midrst_paddr", paddr, 32'd0);
    chk("midrst_pwrite", 32'(pwrite), 32'd0);
    chk("midrst_rdata", m0_rdata | m1_rdata, 32'd0);
    chk("midrst_err", {30'd0, m1_err, m0_err}, 32'd0);
    chk("midrst_no_done1", 32'(n_done[1]), 32'(exp_n[1]));
    exp_rd[0] = 0; exp_rd[1] = 0; exp_er[0] = 0; exp_er[1] = 0;
    ref_last = 1;
    tick();
    post(0, 1'b0, 32'h0000_0100, 32'h0);
    post(1, 1'b0, 32'h0000_0300, 32'h0);
    serve(0, "post_rst_tie");
    serve(0, "post_rst_second");

    repeat (2) tick();
    chk("done_count0", 32'(n_done[0]), 32'(exp_n[0]));
    chk("done_count1", 32'(n_done[1]), 32'(exp_n[1]));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_bus_arbiter.md
# mmio_bus_arbiter

Shares the single MMIO peripheral bus between two requesters: the CPU load/store port (m0) and a secondary master such as DMA or debug (m1). It arbitrates round-robin and runs one APB-style transfer at a time: a setup phase, then an access phase that waits for `pready`. It returns read data or an error to the granted master. A timeout stops a silent peripheral from stalling the pipeline.

## Interface
Parameters:
- `TIMEOUT`, default 16: number of ACCESS cycles without `pready` before the transfer is aborted with an error.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `m0_req`, `m1_req`  in  1 each: transfer request. Held high, with the fields below held stable, until the matching `mN_done`.
- `m0_write`, `m1_write`  in  1 each: 1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  32 each: byte address.
- `m0_wdata`, `m1_wdata`  in  32 each: write data.
- `m0_done`, `m1_done`  out  1 each: one-cycle completion pulse.
- `m0_err`, `m1_err`  out  1 each: valid with `done`; 1 = timeout.
- `m0_rdata`, `m1_rdata`  out  32 each: read data, valid with `done`.
- `paddr`  out  32: bus address.
- `pwdata`  out  32: bus write data.
- `pwrite`  out  1: bus direction.
- `psel`  out  4: one-hot peripheral select, decoded from `addr[9:8]`.
- `penable`  out  1: access phase.
- `pready`  in  1: peripheral completes the access.
- `prdata`  in  32: peripheral read data.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the master that was not served last.
  - On grant, register `paddr`, `pwdata` and `pwrite` from the winner, set `psel[addr[9:8]]`=1, record the winner in `gnt_id`, then go to SETUP.
- SETUP: `psel` one-hot, `penable`=0. Always advances to ACCESS after one cycle.
- ACCESS:
  - `psel` held, `penable`=1, timeout counter increments each cycle.
  - `pready`=1: capture `prdata` (reads only; writes capture 0), set err=0, go to RESP.
  - `pready`=0 and counter reaches TIMEOUT-1: set err=1, rdata=0, go to RESP.
- RESP:
  - `psel`=0, `penable`=0.
  - `m[gnt_id]_done`=1 with its `err` and `rdata`.
  - Update `last` to `gnt_id`, clear the counter, go to IDLE.
- Requesters drop `req` on the clock edge that ends RESP. Arbitration in IDLE therefore sees fresh requests only.
- `rdata` and `err` of each master hold their last values until that master's next `done`. The non-granted master's outputs are never disturbed.
- Counter width is clog2(TIMEOUT+1). It is cleared on entering ACCESS. No wrap-around is reachable.

## Timing
- Reset values: state IDLE, `last`=1 (m0 wins the first tie), all outputs 0 (`psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0, all `done`/`err`/`rdata`=0), counter 0.
- Reset mid-transfer aborts immediately. No `done` is generated, and the bus returns to idle on the next cycle.
- Minimum latency, with `req` seen in IDLE at cycle 0: SETUP at cycle 1, ACCESS at cycle 2 (`pready`=1 sampled), RESP/`done` at cycle 3.
- Each ACCESS wait state adds one cycle.
- Timeout path: `done` with err=1 arrives TIMEOUT cycles after entering ACCESS.
- Back-to-back: a new grant is possible in the IDLE cycle after RESP, so the minimum period is 4 cycles per transfer.
- A request that rises during a transfer waits. It is arbitrated at the next IDLE.
- `pready` outside ACCESS is ignored.
- Any change to `mN_*` fields after grant has no effect, since the bus fields are registered.

## Test plan
- Single read: m0 reads addr 0x0000_0100, `pready`=1 in the first ACCESS cycle, `prdata`=0xDEADBEEF -> `psel`=0b0010, `m0_done` at cycle 3, `m0_rdata`=0xDEADBEEF, `m0_err`=0.
- Write with wait states: m1 writes 0x12345678 to 0x0000_0300, `pready` delayed 3 cycles -> `pwrite`=1, `psel`=0b1000, `penable` high for 4 cycles, `m1_done` at cycle 6.
- Simultaneous requests out of reset: m0 and m1 both request at cycle 0 -> m0 served first, m1 granted in the IDLE after m0's RESP. Repeat with both still requesting -> grants alternate m0, m1, m0.
- Timeout: m0 read with `pready` held 0 -> `m0_done` with `m0_err`=1 and `m0_rdata`=0 exactly 16 cycles after ACCESS entry. The bus is then idle and a new transfer completes normally.
- Reset mid-ACCESS: assert `reset` for 1 cycle during a pending m1 transfer -> no `m1_done`, all outputs 0 the following cycle, and the next tie is won by m0.
- Stray `pready`: pulse `pready` while IDLE and during SETUP -> no state change and no `done`.
